// File: rtl/alu_compare_unit.sv
// RV32I execute-stage ALU plus branch comparator, both registered into a
// single output stage at the EX->MEM boundary.
module alu_compare_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] alu_in1,
  input  logic [XLEN-1:0] alu_in2,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] cmp_in1,
  input  logic [XLEN-1:0] cmp_in2,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result,
  output logic            cond,
  output logic            out_valid
);

  logic [XLEN-1:0] alu_res;
  logic            cmp_res;
  logic [4:0]      shamt;

  logic [XLEN-1:0] result_d, result_q;
  logic            cond_d, cond_q;
  logic            out_valid_d, out_valid_q;

  assign shamt = alu_in2[4:0];

  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      4'd0:    alu_res = alu_in1 + alu_in2;
      4'd1:    alu_res = alu_in1 - alu_in2;
      4'd2:    alu_res = alu_in1 << shamt;
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, $signed(alu_in1) < $signed(alu_in2)};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, alu_in1 < alu_in2};
      4'd5:    alu_res = alu_in1 ^ alu_in2;
      4'd6:    alu_res = alu_in1 >> shamt;
      4'd7:    alu_res = $unsigned($signed(alu_in1) >>> shamt);
      4'd8:    alu_res = alu_in1 | alu_in2;
      4'd9:    alu_res = alu_in1 & alu_in2;
      4'd10:   alu_res = alu_in2;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    cmp_res = 1'b0;
    unique case (funct3)
      3'b000:  cmp_res = (cmp_in1 == cmp_in2);
      3'b001:  cmp_res = (cmp_in1 != cmp_in2);
      3'b100:  cmp_res = ($signed(cmp_in1) <  $signed(cmp_in2));
      3'b101:  cmp_res = ($signed(cmp_in1) >= $signed(cmp_in2));
      3'b110:  cmp_res = (cmp_in1 <  cmp_in2);
      3'b111:  cmp_res = (cmp_in1 >= cmp_in2);
      default: cmp_res = 1'b0;
    endcase
  end

  // Datapath outputs hold across bubbles; only the valid bit tracks every cycle.
  always_comb begin
    out_valid_d = in_valid;
    result_d    = in_valid ? alu_res : result_q;
    cond_d      = in_valid ? cmp_res : cond_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      cond_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      cond_q      <= cond_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign cond      = cond_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_compare_unit.sv
// Self-checking bench for alu_compare_unit: directed cases plus randomized
// traffic against an arithmetic reference model.
module tb_alu_compare_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] alu_in1, alu_in2, cmp_in1, cmp_in2;
  logic [3:0]  alu_op;
  logic [2:0]  funct3;
  logic [31:0] result;
  logic        cond;
  logic        out_valid;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [31:0] exp_result;
  logic        exp_cond;
  logic        exp_valid;

  always #5 clk = ~clk;

  alu_compare_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_op   (alu_op),
    .cmp_in1  (cmp_in1),
    .cmp_in2  (cmp_in2),
    .funct3   (funct3),
    .result   (result),
    .cond     (cond),
    .out_valid(out_valid)
  );

  function automatic longint to_u(input logic [31:0] x);
    return longint'({32'b0, x});
  endfunction

  function automatic longint to_s(input logic [31:0] x);
    return x[31] ? to_u(x) - 64'sd4294967296 : to_u(x);
  endfunction

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    longint      ua = to_u(a);
    longint      ub = to_u(b);
    longint      sa = to_s(a);
    longint      sb = to_s(b);
    int unsigned sh = int'(ub % 32);
    longint      r;
    case (op)
      4'd0:    r = ua + ub;
      4'd1:    r = ua - ub;
      4'd2:    r = ua * (longint'(1) << sh);
      4'd3:    r = (sa < sb) ? 1 : 0;
      4'd4:    r = (ua < ub) ? 1 : 0;
      4'd5:    r = ua ^ ub;
      4'd6:    r = ua / (longint'(1) << sh);
      4'd7:    r = sa >>> sh;
      4'd8:    r = ua | ub;
      4'd9:    r = ua & ub;
      4'd10:   r = ub;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic cmp_model(input logic [31:0] x, input logic [31:0] y,
                                     input logic [2:0] f);
    case (f)
      3'b000:  return x == y;
      3'b001:  return x != y;
      3'b100:  return to_s(x) <  to_s(y);
      3'b101:  return to_s(x) >= to_s(y);
      3'b110:  return to_u(x) <  to_u(y);
      3'b111:  return to_u(x) >= to_u(y);
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic r, input logic v,
                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                      input logic [31:0] c1, input logic [31:0] c2, input logic [2:0] f3,
                      input string tag);
    @(negedge clk);
    rst = r; in_valid = v;
    alu_in1 = a; alu_in2 = b; alu_op = op;
    cmp_in1 = c1; cmp_in2 = c2; funct3 = f3;
    @(posedge clk);
    #1;
    if (r) begin
      exp_result = '0; exp_cond = 1'b0; exp_valid = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        exp_result = alu_model(a, b, op);
        exp_cond   = cmp_model(c1, c2, f3);
      end
    end
    tests++;
    assert (result === exp_result) else begin
      fails++;
      $error("FAIL %s result got %h expected %h", tag, result, exp_result);
    end
    tests++;
    assert (cond === exp_cond) else begin
      fails++;
      $error("FAIL %s cond got %b expected %b", tag, cond, exp_cond);
    end
    tests++;
    assert (out_valid === exp_valid) else begin
      fails++;
      $error("FAIL %s out_valid got %b expected %b", tag, out_valid, exp_valid);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rc1, rc2;
    rst = 1'b1; in_valid = 1'b0;
    alu_in1 = '0; alu_in2 = '0; alu_op = '0;
    cmp_in1 = '0; cmp_in2 = '0; funct3 = '0;
    exp_result = '0; exp_cond = 1'b0; exp_valid = 1'b0;

    step(1, 1, 32'hDEADBEEF, 32'h12345678, 4'd0, 32'h1, 32'h1, 3'b000, "reset0");
    step(1, 1, 32'hCAFEF00D, 32'h0BADF00D, 4'd5, 32'h3, 32'h3, 3'b111, "reset1");

    step(0, 1, 32'hFFFFFFFF, 32'h00000001, 4'd0, 32'h0, 32'h0, 3'b000, "add_wrap");
    step(0, 1, 32'h00000000, 32'h00000001, 4'd1, 32'h0, 32'h1, 3'b000, "sub_wrap");
    step(0, 1, 32'hFFFFFFFF, 32'h00000001, 4'd3, 32'h0, 32'h1, 3'b001, "slt_neg");
    step(0, 1, 32'hFFFFFFFF, 32'h00000001, 4'd4, 32'h0, 32'h1, 3'b001, "sltu_big");

    step(0, 1, 32'h80000000, 32'h00000024, 4'd7, 32'h0, 32'h0, 3'b000, "sra_b5");
    step(0, 1, 32'h80000000, 32'h00000024, 4'd6, 32'h0, 32'h0, 3'b000, "srl_b5");
    step(0, 1, 32'h00000001, 32'd31,       4'd2, 32'h0, 32'h0, 3'b000, "sll_31");

    step(0, 1, 32'hF0F0F0F0, 32'hFF00FF00, 4'd5,  32'h0, 32'h0, 3'b000, "xor");
    step(0, 1, 32'hF0F0F0F0, 32'hFF00FF00, 4'd9,  32'h0, 32'h0, 3'b000, "and");
    step(0, 1, 32'hF0F0F0F0, 32'hFF00FF00, 4'd8,  32'h0, 32'h0, 3'b000, "or");
    step(0, 1, 32'hAAAAAAAA, 32'h12345000, 4'd10, 32'h0, 32'h0, 3'b000, "passb");
    step(0, 1, 32'hAAAAAAAA, 32'h55555555, 4'd13, 32'h0, 32'h0, 3'b000, "op13");

    for (int unsigned f = 0; f < 8; f++)
      step(0, 1, 32'h1, 32'h1, 4'd0, 32'hFFFFFFFE, 32'h00000001, 3'(f), $sformatf("br_m2_f%0d", f));
    step(0, 1, 32'h0, 32'h0, 4'd0, 32'd5, 32'd5, 3'b000, "beq_eq");
    step(0, 1, 32'h0, 32'h0, 4'd0, 32'd5, 32'd5, 3'b101, "bge_eq");
    step(0, 1, 32'h0, 32'h0, 4'd0, 32'd5, 32'd5, 3'b111, "bgeu_eq");

    step(0, 1, 32'd2, 32'd3, 4'd0, 32'd1, 32'd1, 3'b000, "hold_add");
    step(0, 0, 32'd7, 32'd8, 4'd1, 32'd1, 32'd2, 3'b000, "hold_bubble");
    step(0, 1, 32'd9, 32'd4, 4'd1, 32'd1, 32'd2, 3'b001, "hold_sub");
    step(1, 1, 32'd9, 32'd4, 4'd0, 32'd1, 32'd1, 3'b000, "mid_reset");

    for (int unsigned i = 0; i < 300; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rc1 = $urandom;
      rc2 = ($urandom_range(0, 3) == 0) ? rc1 : $urandom;
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0), ra, rb,
           4'($urandom_range(0, 15)), rc1, rc2, 3'($urandom_range(0, 7)),
           $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
